dma_frame_loader: RTL and testbench
===================================

Name: dma_frame_loader

Overview:
- Controller that sequences the 64-bit DMA input buffer for one VAE forward pass.
- Accepts one AXI4-Stream frame of MEM_DEPTH beats from the PYNQ DMA and issues write strobes and addresses to the buffer.
- After the last write, pulses the buffer's output-latch enable and presents a valid/ack handshake to the forward datapath.
- Sits between the DMA AXIS master and the buffer/forward-datapath pair; also reports frame-length errors.

Parameters:
- MEM_DEPTH, 21: beats per frame; number of buffer entries.
- ADDR_WIDTH, 5: buffer address width; must satisfy 2^ADDR_WIDTH >= MEM_DEPTH.
- CNT_WIDTH, 16: width of the completed-frame counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- arm  in  1  one-cycle request to accept the next frame; ignored unless state is IDLE.
- s_axis_tdata  in  64  DMA beat data.
- s_axis_tvalid  in  1  DMA beat valid.
- s_axis_tlast  in  1  DMA end-of-frame marker.
- s_axis_tready  out  1  loader ready; combinational from state (1 in LOAD and DRAIN).
- buf_start  out  1  buffer write strobe (registered).
- buf_addr  out  ADDR_WIDTH  buffer write address (registered).
- buf_din  out  64  buffer write data (registered).
- buf_en_out  out  1  buffer output-latch enable; one-cycle pulse (registered).
- frame_valid  out  1  buffer outputs hold a complete frame.
- frame_ack  in  1  datapath has consumed the frame.
- busy  out  1  state is not IDLE.
- err_short  out  1  sticky: tlast arrived before MEM_DEPTH beats.
- err_long  out  1  sticky: MEM_DEPTH beats arrived without tlast.
- frame_count  out  CNT_WIDTH  number of acknowledged frames; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0.
- Reset mid-operation aborts the frame: s_axis_tready drops in the reset cycle; the partial buffer contents are not latched.
- States: IDLE, LOAD, DRAIN, LATCH, WAIT_OUT, HOLD.
- IDLE -> LOAD on arm. On this transition the beat counter clears; err_short and err_long are NOT cleared.
- Sticky error clearing: err_short and err_long clear only on reset or on arm while both are already set.
- LOAD accepts a beat when s_axis_tvalid & s_axis_tready. For beat index i (0-based), the next cycle has:
  - buf_start=1, buf_addr=i, buf_din=tdata.
  - buf_start is 0 in every cycle with no accepted beat.
- LOAD exits:
  - Beat i=MEM_DEPTH-1 with tlast=1 -> LATCH.
  - Beat i<MEM_DEPTH-1 with tlast=1 -> set err_short; -> LATCH. Unwritten entries keep stale contents.
  - Beat i=MEM_DEPTH-1 with tlast=0 -> set err_long; -> DRAIN.
- DRAIN: tready=1; beats are discarded (buf_start=0) until a beat with tlast is accepted -> LATCH.
- LATCH (one cycle): buf_en_out=1 in the following cycle. The last write (strobe in the LATCH cycle) is committed before the latch samples. Next state WAIT_OUT.
- WAIT_OUT (one cycle): lets the buffer output registers update. Next state HOLD with frame_valid=1.
- Latency: the last accepted beat is at cycle k; buf_start at k+1; buf_en_out at k+2; frame_valid first high at k+3.
- HOLD: frame_valid stays 1 until frame_ack is sampled high. Then frame_valid=0 next cycle, frame_count increments, -> IDLE.
- frame_ack outside HOLD is ignored.
- arm in the same cycle as frame_ack in HOLD is ignored; arm must be re-issued in IDLE.
- tvalid in IDLE/LATCH/WAIT_OUT/HOLD: tready=0, no beat is accepted, no state change.
- buf_addr holds its last value when buf_start=0.

Test Plan:
- Nominal: arm, 21 back-to-back beats with data 64'h100+i and tlast on beat 20 -> buf_addr 0..20 with matching buf_din on consecutive cycles; buf_en_out 1 cycle after the last buf_start; frame_valid 1 cycle later; ack -> frame_count=1, busy=0.
- Throttled source: tvalid low on alternate cycles -> buf_start only on accepted beats, addresses contiguous 0..20; latency from the last beat to frame_valid is still 3 cycles.
- Short frame: tlast on beat 9 -> err_short=1, writes 0..9 only, buf_en_out pulses, frame_valid asserts, err_long=0.
- Long frame: 25 beats, tlast on beat 24 -> writes 0..20 only, beats 21..24 accepted with buf_start=0, err_long=1, frame_valid then asserts.
- Handshake holds: frame_valid held 50 cycles with frame_ack=0 and tvalid=1 -> tready=0 throughout; arm ignored; frame_count unchanged until ack.
- Reset in LOAD after 7 beats -> all outputs 0 next cycle, buf_en_out never pulses; a fresh arm plus a 21-beat frame completes normally with frame_count=1.

Source files
------------

// File: rtl/dma_frame_loader.sv
// Sequences one MEM_DEPTH-beat AXI4-Stream frame into the DMA input buffer, then
// latches the buffer and holds a valid/ack handshake toward the forward datapath.
module dma_frame_loader #(
   parameter int MEM_DEPTH  = 21,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  arm,
   input  logic [63:0]           s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic                  buf_start,
   output logic [ADDR_WIDTH-1:0] buf_addr,
   output logic [63:0]           buf_din,
   output logic                  buf_en_out,
   output logic                  frame_valid,
   input  logic                  frame_ack,
   output logic                  busy,
   output logic                  err_short,
   output logic                  err_long,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, LATCH, WAIT_OUT, HOLD} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] beat_cnt;
   logic                  accept;
   logic                  at_last;

   // Gated by rst_n so the source sees ready drop within the reset cycle itself.
   assign s_axis_tready = rst_n & ((state == LOAD) | (state == DRAIN));
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign at_last       = (beat_cnt == LAST_IDX);
   assign busy          = (state != IDLE);
   assign frame_valid   = (state == HOLD);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (arm) state_nxt = LOAD;
         LOAD: begin
            if (accept) begin
               if (s_axis_tlast)  state_nxt = LATCH;
               else if (at_last)  state_nxt = DRAIN;
            end
         end
         DRAIN:    if (accept && s_axis_tlast) state_nxt = LATCH;
         LATCH:    state_nxt = WAIT_OUT;
         WAIT_OUT: state_nxt = HOLD;
         HOLD:     if (frame_ack) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt    <= '0;
         buf_start   <= 1'b0;
         buf_addr    <= '0;
         buf_din     <= '0;
         buf_en_out  <= 1'b0;
         err_short   <= 1'b0;
         err_long    <= 1'b0;
         frame_count <= '0;
      end else begin
         buf_start  <= 1'b0;
         // The final write strobes during LATCH, so the latch pulse lands one cycle after it.
         buf_en_out <= (state == LATCH);
         if (state == IDLE && arm) begin
            beat_cnt <= '0;
            if (err_short && err_long) begin
               err_short <= 1'b0;
               err_long  <= 1'b0;
            end
         end
         if (state == LOAD && accept) begin
            buf_start <= 1'b1;
            buf_addr  <= beat_cnt;
            buf_din   <= s_axis_tdata;
            beat_cnt  <= beat_cnt + ADDR_WIDTH'(1);
            if (s_axis_tlast && !at_last) err_short <= 1'b1;
            if (!s_axis_tlast && at_last) err_long  <= 1'b1;
         end
         if (state == HOLD && frame_ack) frame_count <= frame_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_dma_frame_loader.sv
// Randomized frame-level bench for dma_frame_loader against a transaction model
// of expected buffer writes, latch timing, sticky errors and frame count.
module tb_dma_frame_loader;

   localparam int D = 21;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arm;
   logic [63:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic        buf_start;
   logic [4:0]  buf_addr;
   logic [63:0] buf_din;
   logic        buf_en_out;
   logic        frame_valid;
   logic        frame_ack;
   logic        busy;
   logic        err_short;
   logic        err_long;
   logic [15:0] frame_count;

   int checks   = 0;
   int failures = 0;

   dma_frame_loader #(.MEM_DEPTH(D), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .buf_start(buf_start), .buf_addr(buf_addr), .buf_din(buf_din),
      .buf_en_out(buf_en_out), .frame_valid(frame_valid), .frame_ack(frame_ack),
      .busy(busy), .err_short(err_short), .err_long(err_long),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observed transactions, sampled mid-cycle
   logic [4:0]  wr_a[$];
   logic [63:0] wr_d[$];
   int  acc_cnt, last_acc, last_wr, en_cnt, en_cyc, fv_cyc;
   bit  fv_prev = 1'b0;

   always @(negedge clk) begin
      if (s_axis_tvalid && s_axis_tready) begin
         acc_cnt++;
         last_acc = cyc;
      end
      if (buf_start) begin
         wr_a.push_back(buf_addr);
         wr_d.push_back(buf_din);
         last_wr = cyc;
      end
      if (buf_en_out) begin
         en_cnt++;
         en_cyc = cyc;
      end
      if (frame_valid && !fv_prev) fv_cyc = cyc;
      fv_prev = frame_valid;
   end

   // Reference model state
   logic [63:0] exp_data [0:31];
   bit m_es, m_el;
   int m_fc;

   task automatic clear_obs();
      wr_a.delete(); wr_d.delete();
      acc_cnt = 0; last_acc = -1; last_wr = -1;
      en_cnt = 0; en_cyc = -1; fv_cyc = -1;
   endtask

   task automatic do_arm();
      if (m_es && m_el) begin
         m_es = 1'b0;
         m_el = 1'b0;
      end
      arm = 1'b1;
      @(posedge clk); #1;
      arm = 1'b0;
   endtask

   task automatic drive_beats(input int n, input int lidx, input bit throttle, output bit to);
      to = 1'b0;
      for (int j = 0; j < n; j++) begin
         if (throttle) begin
            s_axis_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = exp_data[j];
         s_axis_tlast  = (j == lidx);
         begin
            int w = 0;
            @(negedge clk);
            while (!s_axis_tready && w < 50) begin
               @(negedge clk);
               w++;
            end
            if (w >= 50) to = 1'b1;
         end
         @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_fv(output bit to);
      int w = 0;
      @(negedge clk);
      while (!frame_valid && w < 200) begin
         @(negedge clk);
         w++;
      end
      to = !frame_valid;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; arm = 1'b0; frame_ack = 1'b0;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
      m_es = 1'b0; m_el = 1'b0; m_fc = 0;
      clear_obs();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({s_axis_tready, buf_start, buf_addr, buf_din, buf_en_out, frame_valid,
           busy, err_short, err_long, frame_count} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: tready=%b start=%b addr=%0d din=%h en=%b fv=%b busy=%b es=%b el=%b fc=%0d, required all 0",
                  s_axis_tready, buf_start, buf_addr, buf_din, buf_en_out, frame_valid,
                  busy, err_short, err_long, frame_count);
      end
      rst_n = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (s_axis_tready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_tvalid: tready=%b busy=%b, required 0 0", s_axis_tready, busy);
         end
         @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      checks++;
      if (acc_cnt != 0 || wr_a.size() != 0) begin
         failures++;
         $display("FAIL idle_no_accept: accepted=%0d writes=%0d, required 0 0", acc_cnt, wr_a.size());
      end
   endtask

   // One frame of lidx+1 beats, tlast on beat lidx, checked end to end.
   task automatic test_frame(input string nm, input int lidx, input bit throttle, input bit nominal);
      bit to, to2;
      int nw;
      for (int j = 0; j < 32; j++)
         exp_data[j] = nominal ? 64'h100 + 64'(j) : {$urandom, $urandom};
      clear_obs();
      do_arm();
      drive_beats(lidx + 1, lidx, throttle, to);
      wait_fv(to2);
      checks++;
      if (to || to2) begin
         failures++;
         $display("FAIL %s timeout: beat_timeout=%b fv_timeout=%b, required 0 0", nm, to, to2);
      end
      nw = (lidx < D) ? lidx + 1 : D;
      if (lidx < D - 1) m_es = 1'b1;
      if (lidx > D - 1) m_el = 1'b1;
      checks++;
      if (acc_cnt != lidx + 1) begin
         failures++;
         $display("FAIL %s accepted: got %0d beats, required %0d", nm, acc_cnt, lidx + 1);
      end
      checks++;
      if (wr_a.size() != nw) begin
         failures++;
         $display("FAIL %s write_count: got %0d, required %0d", nm, wr_a.size(), nw);
      end
      for (int j = 0; j < nw && j < wr_a.size(); j++) begin
         checks++;
         if (wr_a[j] !== 5'(j) || wr_d[j] !== exp_data[j]) begin
            failures++;
            $display("FAIL %s write[%0d]: addr=%0d din=%h, required addr=%0d din=%h",
                     nm, j, wr_a[j], wr_d[j], j, exp_data[j]);
         end
      end
      if (lidx <= D - 1) begin
         checks++;
         if (last_wr != last_acc + 1) begin
            failures++;
            $display("FAIL %s last_write_cycle: got %0d, required %0d", nm, last_wr, last_acc + 1);
         end
      end
      checks++;
      if (en_cnt != 1 || en_cyc != last_acc + 2) begin
         failures++;
         $display("FAIL %s latch_pulse: count=%0d cycle=%0d, required count=1 cycle=%0d",
                  nm, en_cnt, en_cyc, last_acc + 2);
      end
      checks++;
      if (fv_cyc != last_acc + 3) begin
         failures++;
         $display("FAIL %s frame_valid_cycle: got %0d, required %0d", nm, fv_cyc, last_acc + 3);
      end
      checks++;
      if (err_short !== m_es || err_long !== m_el) begin
         failures++;
         $display("FAIL %s errors: short=%b long=%b, required short=%b long=%b",
                  nm, err_short, err_long, m_es, m_el);
      end
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      m_fc++;
      checks++;
      if (frame_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'(m_fc)) begin
         failures++;
         $display("FAIL %s ack: fv=%b busy=%b count=%0d, required fv=0 busy=0 count=%0d",
                  nm, frame_valid, busy, frame_count, m_fc);
      end
   endtask

   task automatic test_hold();
      bit to, to2;
      int a0, w0;
      for (int j = 0; j < 32; j++) exp_data[j] = {$urandom, $urandom};
      clear_obs();
      do_arm();
      drive_beats(D, D - 1, 1'b0, to);
      wait_fv(to2);
      checks++;
      if (to || to2) begin
         failures++;
         $display("FAIL hold timeout: beat_timeout=%b fv_timeout=%b, required 0 0", to, to2);
      end
      a0 = acc_cnt;
      w0 = wr_a.size();
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b1;
      for (int c = 0; c < 50; c++) begin
         arm = 1'($urandom_range(1, 0));
         @(negedge clk);
         checks++;
         if (s_axis_tready !== 1'b0 || frame_valid !== 1'b1 || busy !== 1'b1 ||
             frame_count !== 16'(m_fc)) begin
            failures++;
            $display("FAIL hold cycle %0d: tready=%b fv=%b busy=%b count=%0d, required 0 1 1 %0d",
                     c, s_axis_tready, frame_valid, busy, frame_count, m_fc);
         end
         @(posedge clk); #1;
      end
      arm = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      checks++;
      if (acc_cnt != a0 || wr_a.size() != w0) begin
         failures++;
         $display("FAIL hold_no_accept: accepted=%0d writes=%0d, required %0d %0d",
                  acc_cnt, wr_a.size(), a0, w0);
      end
      frame_ack = 1'b1;
      arm = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      arm = 1'b0;
      m_fc++;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || frame_valid !== 1'b0 || s_axis_tready !== 1'b0 ||
          frame_count !== 16'(m_fc)) begin
         failures++;
         $display("FAIL ack_with_arm: busy=%b fv=%b tready=%b count=%0d, required 0 0 0 %0d",
                  busy, frame_valid, s_axis_tready, frame_count, m_fc);
      end
      checks++;
      if (err_short !== m_es || err_long !== m_el) begin
         failures++;
         $display("FAIL hold errors: short=%b long=%b, required short=%b long=%b",
                  err_short, err_long, m_es, m_el);
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 8; f++)
         test_frame("random", $urandom_range(27, 0), 1'($urandom_range(1, 0)), 1'b0);
   endtask

   task automatic test_reset_mid_load();
      bit to;
      for (int j = 0; j < 32; j++) exp_data[j] = {$urandom, $urandom};
      clear_obs();
      do_arm();
      drive_beats(7, 99, 1'b0, to);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (s_axis_tready !== 1'b0) begin
         failures++;
         $display("FAIL reset_cycle_tready: got %b, required 0", s_axis_tready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_es = 1'b0; m_el = 1'b0; m_fc = 0;
      checks++;
      if ({s_axis_tready, buf_start, buf_addr, buf_din, buf_en_out, frame_valid,
           busy, err_short, err_long, frame_count} !== '0) begin
         failures++;
         $display("FAIL mid_reset_outputs: tready=%b start=%b addr=%0d din=%h en=%b fv=%b busy=%b fc=%0d, required all 0",
                  s_axis_tready, buf_start, buf_addr, buf_din, buf_en_out, frame_valid,
                  busy, frame_count);
      end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (en_cnt != 0 || frame_valid !== 1'b0 || acc_cnt != 7) begin
         failures++;
         $display("FAIL mid_reset_abort: latch_pulses=%0d fv=%b accepted=%0d, required 0 0 7",
                  en_cnt, frame_valid, acc_cnt);
      end
      test_frame("after_reset", D - 1, 1'b0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_frame("nominal",   D - 1, 1'b0, 1'b1);
      test_frame("throttled", D - 1, 1'b1, 1'b0);
      test_frame("short",     9,     1'b0, 1'b0);
      test_frame("long",      24,    1'b0, 1'b0);
      test_hold();
      test_random_frames();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
